gate_exhaustive_checker: RTL and testbench
==========================================

Name: gate_exhaustive_checker

Overview:
- Hardware stimulus/response checker for the small combinational gates in the combinational-circuits library. It is the receiving and judging end of the gate test interface.
- Sweeps every input vector of an N-input, 1-output gate under test and waits a settle time.
- Samples the gate output and compares it with a parameterised truth table.
- Reports the error count, the first failing vector, and pass/done status.
- Sits beside any gate instance in a synthesizable self-test wrapper, replacing hand-written tst benches.

Parameters:
- N_IN, 2: number of gate inputs. Legal range 1..6.
- SETTLE, 2: cycles each vector is held before sampling. Must be at least 1.
- TRUTH, 4'b1000: expected output per vector, width 2**N_IN. Bit i is the expected output when dut_in == i. The default is a 2-input AND.

Ports:
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a sweep; sampled only in IDLE or DONE
- dut_in  out  N_IN  vector driven to the gate inputs; bit 0 = LSB input
- dut_out  in  1  gate output under test
- busy  out  1  high while a sweep is in progress
- done  out  1  high from sweep completion until the next start or reset
- pass  out  1  done && err_count == 0
- err_count  out  N_IN+1  number of mismatching vectors in the last sweep
- first_err_valid  out  1  at least one mismatch seen this sweep
- first_err_vec  out  N_IN  first mismatching vector; 0 when first_err_valid is 0

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- While rst_n = 0, all outputs are 0: dut_in, busy, done, pass, err_count, first_err_valid, first_err_vec. State = IDLE.
- FSM states: IDLE, HOLD, SAMPLE, DONE.
- IDLE or DONE, start = 1 at an edge:
  - vec <= 0, hold_cnt <= 0.
  - err_count, first_err_valid and first_err_vec cleared.
  - done <= 0, state <= HOLD.
- HOLD:
  - dut_in = vec, busy = 1.
  - hold_cnt increments each edge.
  - When hold_cnt == SETTLE-1, hold_cnt <= 0 and state <= SAMPLE.
- SAMPLE (one cycle):
  - dut_out is compared with TRUTH[vec].
  - On mismatch: err_count <= err_count + 1. If first_err_valid is 0, also set first_err_valid <= 1 and first_err_vec <= vec.
  - If vec == 2**N_IN - 1, state <= DONE; otherwise vec <= vec + 1 and state <= HOLD.
- Timing:
  - Each vector is driven for exactly SETTLE+1 cycles and sampled at the last edge of that window.
  - done rises exactly 2**N_IN * (SETTLE+1) edges after the edge that accepted start.
- DONE:
  - busy = 0, done = 1; pass is combinational from done and err_count.
  - dut_in holds the last vector.
  - Results hold until the next accepted start.
- start while busy: ignored, no restart.
- start held high continuously: a new sweep begins each time DONE is entered (back-to-back sweeps). done is high for exactly one cycle between sweeps.
- Vector counter: never wraps inside a sweep; the terminal vector is detected explicitly.
- err_count: cannot overflow, since its maximum is 2**N_IN and it is N_IN+1 bits wide.
- Reset mid-sweep: immediate abort, all outputs to reset values, no partial results retained.
- dut_out is treated as synchronous to clk. No synchronizer is inside the block.

Decomposition:
- Shared package gate_test_pkg:
  - typedef enum logic [1:0] chk_state_t {IDLE, HOLD, SAMPLE, DONE}.
  - Function expected_bit(truth, vec).
- The package is reused by future multi-output checkers.
- No sub-module; the FSM, hold counter and vector counter live in one module.
- The bench provides behavioural gate models (and/or/stuck-at) as DUT stand-ins.

Test Plan:
- Correct AND gate, defaults, start pulsed 1 cycle:
  - dut_in steps 0,1,2,3, each held 3 cycles.
  - done rises 12 edges after start.
  - pass = 1, err_count = 0, first_err_valid = 0.
- OR gate wired in, defaults: err_count = 2, first_err_vec = 1, first_err_valid = 1, pass = 0.
- Stuck-at-1 output: err_count = 3, first_err_vec = 0. Then apply start again with a correct AND: counters cleared, pass = 1.
- rst_n asserted asynchronously while dut_in = 2:
  - All outputs 0 within the same cycle, before the next edge.
  - A subsequent start runs a full 12-cycle sweep.
- start pulsed at cycles 4 and 8 of a sweep: ignored; done still at edge 12. start held high: one-cycle done pulse, then the sweep restarts.
- N_IN = 3, SETTLE = 1, TRUTH = 8'h96, 3-input XOR model: done after 16 edges, pass = 1. With an inverted XOR: err_count = 8, first_err_vec = 0.

Source files
------------

// File: rtl/gate_test_pkg.sv
// Shared types and helpers for the gate stimulus/response checkers.
// Reused by single- and multi-output checker variants.
package gate_test_pkg;

  localparam int MAX_N_IN    = 6;
  localparam int MAX_TRUTH_W = 2 ** MAX_N_IN;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SAMPLE,
    DONE
  } chk_state_t;

  // Truth tables are zero-extended to the widest legal gate so one helper serves every N_IN.
  function automatic logic expected_bit(input logic [MAX_TRUTH_W-1:0] truth,
                                        input logic [MAX_N_IN-1:0]    vec);
    return truth[vec];
  endfunction

endpackage

// File: rtl/gate_exhaustive_checker.sv
// Exhaustive checker for an N-input, 1-output gate: sweeps every input vector,
// holds it for SETTLE cycles, samples the gate output and compares it with TRUTH.
module gate_exhaustive_checker
  import gate_test_pkg::*;
#(
  parameter int                  N_IN   = 2,
  parameter int                  SETTLE = 2,
  parameter logic [2**N_IN-1:0]  TRUTH  = 4'b1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_err_valid,
  output logic [N_IN-1:0] first_err_vec
);

  localparam int                     CNT_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]        LAST_VEC  = '1;
  localparam logic [MAX_TRUTH_W-1:0] TRUTH_EXT = MAX_TRUTH_W'(TRUTH);

  chk_state_t       state;
  chk_state_t       state_nxt;
  logic [N_IN-1:0]  vec;
  logic [CNT_W-1:0] hold_cnt;
  logic [N_IN:0]    err_cnt;
  logic             fe_valid;
  logic [N_IN-1:0]  fe_vec;
  logic             mismatch;
  logic             hold_end;
  logic             last_vec;

  assign mismatch = (dut_out != expected_bit(TRUTH_EXT, MAX_N_IN'(vec)));
  assign hold_end = (hold_cnt == HOLD_LAST);
  assign last_vec = (vec == LAST_VEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (hold_end) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        // The terminal vector is detected explicitly so the counter never wraps mid-sweep.
        if (last_vec) begin
          state_nxt = DONE;
        end else begin
          state_nxt = HOLD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec      <= '0;
      hold_cnt <= '0;
      err_cnt  <= '0;
      fe_valid <= 1'b0;
      fe_vec   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec      <= '0;
            hold_cnt <= '0;
            err_cnt  <= '0;
            fe_valid <= 1'b0;
            fe_vec   <= '0;
          end
        end
        HOLD: begin
          if (hold_end) begin
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            err_cnt <= err_cnt + 1'b1;
            if (!fe_valid) begin
              fe_valid <= 1'b1;
              fe_vec   <= vec;
            end
          end
          if (!last_vec) begin
            vec <= vec + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // vec is left at the terminal value after a sweep so dut_in keeps showing the last vector.
  assign dut_in          = vec;
  assign busy            = (state == HOLD) || (state == SAMPLE);
  assign done            = (state == DONE);
  assign pass            = done && (err_cnt == '0);
  assign err_count       = err_cnt;
  assign first_err_valid = fe_valid;
  assign first_err_vec   = fe_vec;

endmodule

// File: tb/tb_gate_exhaustive_checker.sv
// Scoreboard bench for gate_exhaustive_checker: a 2-input AND-table checker and a
// 3-input XOR-table checker, each driven by behavioural gate stand-ins.
module tb_gate_exhaustive_checker;

  localparam int G_AND  = 0;
  localparam int G_OR   = 1;
  localparam int G_ST0  = 2;
  localparam int G_ST1  = 3;
  localparam int G_XOR  = 4;
  localparam int G_XNOR = 5;
  localparam int G_RAND = 6;

  typedef struct {
    int errs;
    int first_vec;
    bit first_valid;
    bit pass_exp;
    int done_edge;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start2, start3;

  logic [1:0] dut_in2;
  logic       dut_out2, busy2, done2, pass2, fev2;
  logic [2:0] err2;
  logic [1:0] fevec2;

  logic [2:0] dut_in3;
  logic       dut_out3, busy3, done3, pass3, fev3;
  logic [3:0] err3;
  logic [2:0] fevec3;

  int          kind2 = G_AND;
  int          kind3 = G_XOR;
  logic [63:0] tbl2  = '0;
  logic [63:0] tbl3  = '0;

  exp_t q2[$];
  exp_t q3[$];
  exp_t m2, m3;
  logic done2_q = 1'b0;
  logic done3_q = 1'b0;

  int edge_cnt = 0;
  int tests    = 0;
  int fails    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic gateModel(int kind, int n, int v, logic [63:0] tbl);
    case (kind)
      G_AND:   return v == ((1 << n) - 1);
      G_OR:    return v != 0;
      G_ST0:   return 1'b0;
      G_ST1:   return 1'b1;
      G_XOR:   return ($countones(v) % 2) == 1;
      G_XNOR:  return ($countones(v) % 2) == 0;
      default: return tbl[v];
    endcase
  endfunction

  assign dut_out2 = gateModel(kind2, 2, int'(dut_in2), tbl2);
  assign dut_out3 = gateModel(kind3, 3, int'(dut_in3), tbl3);

  gate_exhaustive_checker #(.N_IN(2), .SETTLE(2), .TRUTH(4'b1000)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_in(dut_in2), .dut_out(dut_out2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_err_valid(fev2), .first_err_vec(fevec2)
  );

  gate_exhaustive_checker #(.N_IN(3), .SETTLE(1), .TRUTH(8'h96)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .dut_in(dut_in3), .dut_out(dut_out3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_err_valid(fev3), .first_err_vec(fevec3)
  );

  // Expected sweep result straight from the truth table: count disagreeing vectors.
  function automatic exp_t refModel(int n, int settle, logic [63:0] truth, int kind,
                                    logic [63:0] tbl, int acc);
    exp_t e;
    e.errs = 0; e.first_vec = 0; e.first_valid = 1'b0;
    for (int v = 0; v < (1 << n); v++) begin
      if (gateModel(kind, n, v, tbl) != truth[v]) begin
        if (!e.first_valid) begin
          e.first_valid = 1'b1;
          e.first_vec   = v;
        end
        e.errs++;
      end
    end
    e.pass_exp  = (e.errs == 0);
    e.done_edge = acc + (1 << n) * (settle + 1);
    return e;
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic exp_t expectFor(int sel, int kind, logic [63:0] tbl, int acc);
    if (sel == 2) return refModel(2, 2, 64'h8, kind, tbl, acc);
    return refModel(3, 1, 64'h96, kind, tbl, acc);
  endfunction

  // Drives one accepted start and pushes the expected sweep result.
  task automatic applyStimulus(int sel, int kind, logic [63:0] tbl, output int acc);
    @(negedge clk);
    if (sel == 2) begin kind2 = kind; tbl2 = tbl; start2 = 1'b1; end
    else          begin kind3 = kind; tbl3 = tbl; start3 = 1'b1; end
    @(posedge clk);
    #1;
    acc = edge_cnt;
    if (sel == 2) begin q2.push_back(expectFor(2, kind, tbl, acc)); start2 = 1'b0; end
    else          begin q3.push_back(expectFor(3, kind, tbl, acc)); start3 = 1'b0; end
  endtask

  task automatic waitDone(int sel, int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sel == 2 && done2) || (sel == 3 && done3)) return;
    end
    checkOutput($sformatf("done_timeout_dut%0d", sel), 0, 1);
  endtask

  task automatic checkResetOutputs(string tag);
    checkOutput({tag, "_dut_in2"}, int'(dut_in2), 0);
    checkOutput({tag, "_busy2"},   int'(busy2),   0);
    checkOutput({tag, "_done2"},   int'(done2),   0);
    checkOutput({tag, "_pass2"},   int'(pass2),   0);
    checkOutput({tag, "_err2"},    int'(err2),    0);
    checkOutput({tag, "_fev2"},    int'(fev2),    0);
    checkOutput({tag, "_fevec2"},  int'(fevec2),  0);
    checkOutput({tag, "_all3"},
                int'({dut_in3, busy3, done3, pass3, err3, fev3, fevec3}), 0);
  endtask

  // Monitors: each rising done retires the oldest expected sweep for that checker.
  always @(negedge clk) begin
    if (done2 && !done2_q) begin
      if (q2.size() == 0) begin
        checkOutput("dut2_unexpected_done", 1, 0);
      end else begin
        m2 = q2.pop_front();
        checkOutput("dut2_done_edge", edge_cnt, m2.done_edge);
        checkOutput("dut2_err_count", int'(err2), m2.errs);
        checkOutput("dut2_first_err_valid", int'(fev2), int'(m2.first_valid));
        checkOutput("dut2_first_err_vec", int'(fevec2), m2.first_vec);
        checkOutput("dut2_pass", int'(pass2), int'(m2.pass_exp));
        checkOutput("dut2_busy_at_done", int'(busy2), 0);
      end
    end
    done2_q <= done2;
  end

  always @(negedge clk) begin
    if (done3 && !done3_q) begin
      if (q3.size() == 0) begin
        checkOutput("dut3_unexpected_done", 1, 0);
      end else begin
        m3 = q3.pop_front();
        checkOutput("dut3_done_edge", edge_cnt, m3.done_edge);
        checkOutput("dut3_err_count", int'(err3), m3.errs);
        checkOutput("dut3_first_err_valid", int'(fev3), int'(m3.first_valid));
        checkOutput("dut3_first_err_vec", int'(fevec3), m3.first_vec);
        checkOutput("dut3_pass", int'(pass3), int'(m3.pass_exp));
        checkOutput("dut3_dut_in_last", int'(dut_in3), 7);
      end
    end
    done3_q <= done3;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int sel, kind, gap, found;
    logic [63:0] tbl;

    rst_n = 1'b0; start2 = 1'b0; start3 = 1'b0;
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;

    // Correct AND: vector staircase and done exactly 12 edges after start.
    applyStimulus(2, G_AND, '0, acc);
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      checkOutput($sformatf("and_dut_in_k%0d", k), int'(dut_in2), (k < 12) ? k / 3 : 3);
      checkOutput($sformatf("and_done_k%0d", k), int'(done2), (k == 12) ? 1 : 0);
    end
    checkOutput("and_pass", int'(pass2), 1);

    applyStimulus(2, G_OR, '0, acc);
    waitDone(2, 40);
    checkOutput("or_err_count", int'(err2), 2);
    checkOutput("or_first_vec", int'(fevec2), 1);
    checkOutput("or_first_valid", int'(fev2), 1);
    checkOutput("or_pass", int'(pass2), 0);

    applyStimulus(2, G_ST1, '0, acc);
    waitDone(2, 40);
    checkOutput("st1_err_count", int'(err2), 3);
    checkOutput("st1_first_vec", int'(fevec2), 0);
    applyStimulus(2, G_AND, '0, acc);
    waitDone(2, 40);
    checkOutput("rerun_err_count", int'(err2), 0);
    checkOutput("rerun_first_valid", int'(fev2), 0);
    checkOutput("rerun_pass", int'(pass2), 1);

    // Asynchronous abort while vector 2 is on the gate inputs.
    applyStimulus(2, G_OR, '0, acc);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (dut_in2 == 2'd2) found = 1;
    end
    checkOutput("reached_vec2", found, 1);
    #1 rst_n = 1'b0;
    #1 checkResetOutputs("async_reset");
    q2.delete();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2, G_AND, '0, acc);
    waitDone(2, 40);

    // Starts during a sweep must not restart it; the monitor checks done at edge 12.
    applyStimulus(2, G_ST0, '0, acc);
    repeat (3) @(negedge clk);
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    repeat (3) @(negedge clk);
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    waitDone(2, 40);

    // start held high: two back-to-back sweeps with a single-cycle done between them.
    applyStimulus(2, G_AND, '0, acc);
    start2 = 1'b1;
    q2.push_back(expectFor(2, G_AND, '0, acc + 13));
    waitDone(2, 40);
    @(negedge clk);
    checkOutput("b2b_done_pulse", int'(done2), 0);
    checkOutput("b2b_busy_again", int'(busy2), 1);
    start2 = 1'b0;
    waitDone(2, 40);

    applyStimulus(3, G_XOR, '0, acc);
    waitDone(3, 40);
    checkOutput("xor3_pass", int'(pass3), 1);
    applyStimulus(3, G_XNOR, '0, acc);
    waitDone(3, 40);
    checkOutput("xnor3_err_count", int'(err3), 8);
    checkOutput("xnor3_first_vec", int'(fevec3), 0);

    // Randomized gates and truth tables, with an occasional ignored mid-sweep start.
    for (int it = 0; it < 24; it++) begin
      sel  = ($urandom_range(0, 1) == 0) ? 2 : 3;
      kind = $urandom_range(0, 6);
      tbl  = {$urandom(), $urandom()};
      applyStimulus(sel, kind, tbl, acc);
      if ($urandom_range(0, 1) == 1) begin
        gap = $urandom_range(1, 8);
        repeat (gap) @(negedge clk);
        if (sel == 2) start2 = 1'b1; else start3 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; start3 = 1'b0;
      end
      waitDone(sel, 40);
    end

    repeat (3) @(negedge clk);
    checkOutput("q2_drained", q2.size(), 0);
    checkOutput("q3_drained", q3.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
